// File: rtl/fpmult_accum_if.sv
// Valid/ready stream carrying one W-bit word per transfer.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface fpmult_accum_if #(
   parameter int W = 32
);
   logic         val;
   logic         rdy;
   logic [W-1:0] msg;

   modport master (output val, output msg, input  rdy);
   modport slave  (input  val, input  msg, output rdy);
endinterface

// File: rtl/fpmult_accum.sv
// Sums groups of m signed Qn-d.d products and emits one n-bit result per group.
// Define FPMULT_ACCUM_SAT_EN to saturate the result; otherwise the result wraps.
module fpmult_accum #(
   parameter int n = 32,
   parameter int d = 16,
   parameter int m = 4
) (
   input  logic              clk,
   input  logic              reset,
   fpmult_accum_if.slave     recv,
   fpmult_accum_if.master    send
);
   localparam int G = (m > 1) ? $clog2(m) : 1;
   localparam int A = n + G;
   localparam logic [7:0] LAST = 8'(m - 1);

   if ((m < 1) || (m > 255)) begin : g_bad_m
      $error("fpmult_accum: m must be in 1..255");
   end
   if ((d < 0) || (d >= n)) begin : g_bad_d
      $error("fpmult_accum: d must be in 0..n-1");
   end

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   state_e         state_q;
   logic [A-1:0]   acc_q;
   logic [A-1:0]   acc_d;
   logic [7:0]     cnt_q;
   logic           recv_rdy_q;
   logic           send_val_q;
   logic [n-1:0]   send_msg_q;
   logic [n-1:0]   res_s;
   logic           accept_s;

`ifdef FPMULT_ACCUM_SAT_EN
   // Clamp when the guard bits and bit n-1 disagree.
   function automatic logic [n-1:0] sat_f(input logic [A-1:0] a);
      logic [G:0] top;
      top = a[A-1:n-1];
      if ((&top) || (~|top)) begin
         return a[n-1:0];
      end else if (a[A-1]) begin
         return {1'b1, {(n-1){1'b0}}};
      end else begin
         return {1'b0, {(n-1){1'b1}}};
      end
   endfunction

   assign res_s = sat_f(acc_d);
`else
   assign res_s = acc_d[n-1:0];
`endif

   // recv_rdy_q is only ever high in ST_ACC, so it alone qualifies an accept.
   assign accept_s = recv.val & recv_rdy_q;

   always_comb begin
      acc_d = acc_q + {{G{recv.msg[n-1]}}, recv.msg};
   end

   assign recv.rdy = recv_rdy_q;
   assign send.val = send_val_q;
   assign send.msg = send_msg_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ACC;
         acc_q      <= {A{1'b0}};
         cnt_q      <= 8'd0;
         recv_rdy_q <= 1'b1;
         send_val_q <= 1'b0;
         send_msg_q <= {n{1'b0}};
      end else begin
         case (state_q)
            ST_ACC: begin
               if (accept_s) begin
                  acc_q <= acc_d;
                  if (cnt_q == LAST) begin
                     // Result is computed from the final sum so it is valid on entry to DONE.
                     cnt_q      <= 8'd0;
                     state_q    <= ST_DONE;
                     recv_rdy_q <= 1'b0;
                     send_val_q <= 1'b1;
                     send_msg_q <= res_s;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            ST_DONE: begin
               if (send.rdy) begin
                  acc_q      <= {A{1'b0}};
                  state_q    <= ST_ACC;
                  recv_rdy_q <= 1'b1;
                  send_val_q <= 1'b0;
                  send_msg_q <= {n{1'b0}};
               end
            end
            default: begin
               state_q    <= ST_ACC;
               acc_q      <= {A{1'b0}};
               cnt_q      <= 8'd0;
               recv_rdy_q <= 1'b1;
               send_val_q <= 1'b0;
               send_msg_q <= {n{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fpmult_accum.sv
// Directed bench for fpmult_accum (n=32, d=16, m=4) with hand-computed results.
// Expected overflow results follow FPMULT_ACCUM_SAT_EN when it is defined.
module tb_fpmult_accum;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fpmult_accum_if #(.W(32)) r_if ();
   fpmult_accum_if #(.W(32)) s_if ();

   fpmult_accum #(.n(32), .d(16), .m(4)) dut (
      .clk   (clk),
      .reset (reset),
      .recv  (r_if.slave),
      .send  (s_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FPMULT_ACCUM_SAT_EN
   localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
   localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
   localparam logic [31:0] POS_OVF = 32'h0000_0000;
   localparam logic [31:0] NEG_OVF = 32'h0000_0000;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      r_if.val = 1'b1;
      r_if.msg = v;
      tick();
      r_if.val = 1'b0;
      r_if.msg = 32'h0;
   endtask

   // Pushes four products, checks latency and result, then drains with send_rdy.
   task automatic group(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3,
                        input logic [31:0] exp, input bit drain);
      check_val({tag, "_rdy_start"}, 32'(r_if.rdy), 32'd1);
      push(v0);
      push(v1);
      push(v2);
      check_val({tag, "_val_before_last"}, 32'(s_if.val), 32'd0);
      push(v3);
      check_val({tag, "_val"}, 32'(s_if.val), 32'd1);
      check_val({tag, "_msg"}, s_if.msg, exp);
      check_val({tag, "_rdy_done"}, 32'(r_if.rdy), 32'd0);
      if (drain) begin
         s_if.rdy = 1'b1;
         tick();
         s_if.rdy = 1'b0;
         check_val({tag, "_val_after"}, 32'(s_if.val), 32'd0);
         check_val({tag, "_msg_after"}, s_if.msg, 32'h0);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      r_if.val = 1'b0;
      r_if.msg = 32'h0;
      s_if.rdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_val("reset_recv_rdy", 32'(r_if.rdy), 32'd1);
      check_val("reset_send_val", 32'(s_if.val), 32'd0);
      check_val("reset_send_msg", s_if.msg, 32'h0);

      group("nominal", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0004_0000, 1'b1);

      // send_rdy held high through ACC must not disturb accumulation.
      s_if.rdy = 1'b1;
      group("mixed", 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000,
            32'h0001_0000, 1'b0);
      tick();
      check_val("mixed_val_after", 32'(s_if.val), 32'd0);
      s_if.rdy = 1'b0;

      group("pos_ovf", 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
            POS_OVF, 1'b1);
      group("neg_ovf", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            NEG_OVF, 1'b1);

      group("bp", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0004_0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         r_if.val = i[0];
         r_if.msg = 32'h1234_5678;
         tick();
         check_val("bp_val", 32'(s_if.val), 32'd1);
         check_val("bp_msg", s_if.msg, 32'h0004_0000);
         check_val("bp_rdy", 32'(r_if.rdy), 32'd0);
      end
      r_if.val = 1'b0;
      r_if.msg = 32'h0;
      s_if.rdy = 1'b1;
      tick();
      s_if.rdy = 1'b0;
      group("bp_next", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0004_0000, 1'b1);

      push(32'h0005_0000);
      push(32'h0005_0000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("midrst_val", 32'(s_if.val), 32'd0);
      check_val("midrst_rdy", 32'(r_if.rdy), 32'd1);
      group("midrst", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0004_0000, 1'b0);

      // Reset while DONE is pending drops the result.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("donerst_val", 32'(s_if.val), 32'd0);
      check_val("donerst_msg", s_if.msg, 32'h0);
      check_val("donerst_rdy", 32'(r_if.rdy), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
